avl_arbiter: RTL and testbench

AVL_ARBITER -- requirements
Module: avl_arbiter

---
 rtl/avl_arbiter.sv | 147 ++++++++++++++
 tb/tb_avl_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avl_arbiter.sv
// avl_arbiter: three-requester round-robin arbiter in front of an Avalon-MM
// DDR controller port. A requester owns the bus until it releases (unlocked
// and either a command accepted or nothing pending); outstanding reads are
// counted so read beats can be routed back and the bus drained before the
// next owner is granted.
module avl_arbiter (
  input  logic         clk,
  input  logic         reset,
  input  logic         local_init_done,
  input  logic         avl_wait_request_n,
  input  logic         avl_readdatavalid,
  input  logic [127:0] avl_readdata,
  output logic         avl_burstbegin,
  output logic [25:0]  avl_address,
  output logic [127:0] avl_writedata,
  output logic         avl_write,
  output logic         avl_read,
  input  logic [2:0]   req_valid,
  input  logic [2:0]   req_write,
  input  logic [2:0]   req_lock,
  input  logic [77:0]  req_address,
  input  logic [383:0] req_writedata,
  output logic [2:0]   req_ready,
  output logic [2:0]   rd_valid,
  output logic [127:0] rd_data,
  output logic [1:0]   owner,
  output logic         busy,
  output logic         protocol_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  owner_reg, owner_next;
  logic [1:0]  last_owner_reg, last_owner_next;
  logic [3:0]  outstanding_reg, outstanding_next;
  logic        protocol_err_reg, protocol_err_next;

  // Flattened per-requester buses unpacked into arrays for owner-indexed muxing.
  logic [25:0]  addr_arr  [3];
  logic [127:0] wdata_arr [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_address[gi*26 +: 26];
      assign wdata_arr[gi] = req_writedata[gi*128 +: 128];
    end
  endgenerate

  logic       own;
  logic       sel_valid, sel_write, sel_lock;
  logic       accept;
  logic       inc, dec;
  logic [1:0] rr_first, rr_second, rr_third, rr_pick;

  // Round-robin candidate order starts just after the previous owner.
  always_comb begin
    rr_first  = (last_owner_reg == 2'd2) ? 2'd0 : last_owner_reg + 2'd1;
    rr_second = (rr_first == 2'd2) ? 2'd0 : rr_first + 2'd1;
    rr_third  = (rr_second == 2'd2) ? 2'd0 : rr_second + 2'd1;
    rr_pick   = rr_third;
    if (req_valid[rr_second]) rr_pick = rr_second;
    if (req_valid[rr_first])  rr_pick = rr_first;
  end

  // Command path: the owner's request is presented directly while in OWN;
  // reads are withheld once 15 are in flight so the counter cannot wrap.
  always_comb begin
    own            = (state_reg == OWN);
    sel_valid      = req_valid[owner_reg];
    sel_write      = req_write[owner_reg];
    sel_lock       = req_lock[owner_reg];
    avl_write      = own & sel_valid & sel_write;
    avl_read       = own & sel_valid & ~sel_write & (outstanding_reg != 4'd15);
    avl_burstbegin = avl_read | avl_write;
    accept         = avl_burstbegin & avl_wait_request_n;
    req_ready      = accept ? (3'b001 << owner_reg) : 3'b000;
    avl_address    = own ? addr_arr[owner_reg] : 26'd0;
    avl_writedata  = own ? wdata_arr[owner_reg] : 128'd0;
    rd_valid       = ((state_reg != IDLE) && avl_readdatavalid) ? (3'b001 << owner_reg) : 3'b000;
    rd_data        = avl_readdata;
    owner          = owner_reg;
    busy           = (state_reg != IDLE);
    protocol_err   = protocol_err_reg;
  end

  // Outstanding-read bookkeeping and the sticky stray-beat error.
  always_comb begin
    inc = accept & avl_read;
    dec = avl_readdatavalid & (outstanding_reg != 4'd0);
    outstanding_next = outstanding_reg;
    case ({inc, dec})
      2'b10:   outstanding_next = outstanding_reg + 4'd1;
      2'b01:   outstanding_next = outstanding_reg - 4'd1;
      default: outstanding_next = outstanding_reg;
    endcase
    protocol_err_next = protocol_err_reg | (avl_readdatavalid & (outstanding_reg == 4'd0));
  end

  // Next-state logic: grant in IDLE, release from OWN, wait out reads in DRAIN.
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    case (state_reg)
      IDLE: begin
        if (local_init_done && (|req_valid)) begin
          owner_next = rr_pick;
          state_next = OWN;
        end
      end
      OWN: begin
        if (!sel_lock && (accept || !sel_valid)) begin
          last_owner_next = owner_reg;
          state_next      = (outstanding_next != 4'd0) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (outstanding_reg == 4'd0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any reads still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      owner_reg        <= 2'd0;
      last_owner_reg   <= 2'd2;
      outstanding_reg  <= 4'd0;
      protocol_err_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      owner_reg        <= owner_next;
      last_owner_reg   <= last_owner_next;
      outstanding_reg  <= outstanding_next;
      protocol_err_reg <= protocol_err_next;
    end
  end

endmodule

// File: tb/tb_avl_arbiter.sv
// Directed testbench for avl_arbiter: one task per scenario, inline checks.
module tb_avl_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         local_init_done;
  logic         avl_wait_request_n;
  logic         avl_readdatavalid;
  logic [127:0] avl_readdata;
  logic         avl_burstbegin;
  logic [25:0]  avl_address;
  logic [127:0] avl_writedata;
  logic         avl_write;
  logic         avl_read;
  logic [2:0]   req_valid;
  logic [2:0]   req_write;
  logic [2:0]   req_lock;
  logic [77:0]  req_address;
  logic [383:0] req_writedata;
  logic [2:0]   req_ready;
  logic [2:0]   rd_valid;
  logic [127:0] rd_data;
  logic [1:0]   owner;
  logic         busy;
  logic         protocol_err;

  int total = 0;
  int bad   = 0;

  avl_arbiter dut (
    .clk(clk), .reset(reset), .local_init_done(local_init_done),
    .avl_wait_request_n(avl_wait_request_n), .avl_readdatavalid(avl_readdatavalid),
    .avl_readdata(avl_readdata), .avl_burstbegin(avl_burstbegin),
    .avl_address(avl_address), .avl_writedata(avl_writedata),
    .avl_write(avl_write), .avl_read(avl_read),
    .req_valid(req_valid), .req_write(req_write), .req_lock(req_lock),
    .req_address(req_address), .req_writedata(req_writedata),
    .req_ready(req_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .owner(owner), .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    local_init_done    = 1'b0;
    avl_wait_request_n = 1'b0;
    avl_readdatavalid  = 1'b0;
    avl_readdata       = '0;
    req_valid          = '0;
    req_write          = '0;
    req_lock           = '0;
    req_address        = '0;
    req_writedata      = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    settle();
  endtask

  // Waits (bounded) until a command is presented on the avl side.
  task automatic wait_cmd(output bit ok);
    ok = 1'b0;
    settle();
    for (int n = 0; n < 20; n++) begin
      if (avl_read === 1'b1 || avl_write === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #2;
    total++;
    if ({busy, owner, protocol_err, avl_read, avl_write, avl_burstbegin} !== 6'b0 ||
        avl_address !== 26'd0 || avl_writedata !== 128'd0 || req_ready !== 3'b000 || rd_valid !== 3'b000) begin
      bad++;
      $display("FAIL reset_outputs: busy=%0b owner=%0d err=%0b rd=%0b wr=%0b addr=%h ready=%b rdv=%b, required all zero",
               busy, owner, protocol_err, avl_read, avl_write, avl_address, req_ready, rd_valid);
    end
    tick();
    reset = 1'b0;
    settle();
    $display("test_reset: done");
  endtask

  task automatic test_init_gating();
    do_reset();
    avl_wait_request_n = 1'b1;
    req_valid = 3'b111;
    req_address = {26'h30, 26'h20, 26'h10};
    for (int c = 0; c < 20; c++) begin
      settle();
      total++;
      if (avl_read !== 1'b0 || avl_write !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL init_gate_cycle%0d: rd=%0b wr=%0b busy=%0b, required 0 0 0", c, avl_read, avl_write, busy);
      end
      tick();
    end
    local_init_done = 1'b1;
    tick();
    settle();
    total++;
    if (busy !== 1'b1 || owner !== 2'd0 || avl_read !== 1'b1 || avl_address !== 26'h10) begin
      bad++;
      $display("FAIL init_grant: busy=%0b owner=%0d rd=%0b addr=%h, required 1 0 1 010", busy, owner, avl_read, avl_address);
    end
    $display("test_init_gating: done");
  endtask

  task automatic test_round_robin();
    logic [1:0]   exp_owner [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [25:0]  exp_addr  [4] = '{26'h10, 26'h20, 26'h30, 26'h10};
    logic [127:0] beat;
    bit ok;
    do_reset();
    local_init_done = 1'b1;
    avl_wait_request_n = 1'b1;
    req_address = {26'h30, 26'h20, 26'h10};
    req_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_cmd(ok);
      total++;
      if (!ok || owner !== exp_owner[k] || avl_read !== 1'b1 || avl_address !== exp_addr[k] ||
          req_ready !== (3'b001 << exp_owner[k])) begin
        bad++;
        $display("FAIL rr_grant%0d: ok=%0b owner=%0d rd=%0b addr=%h ready=%b, required owner=%0d addr=%h",
                 k, ok, owner, avl_read, avl_address, req_ready, exp_owner[k], exp_addr[k]);
      end
      tick();
      if (k == 1) req_valid[1] = 1'b0;
      if (k == 2) req_valid[2] = 1'b0;
      if (k == 3) req_valid = 3'b000;
      beat = {4{32'hC0DE0000 + 32'(k)}};
      avl_readdata = beat;
      avl_readdatavalid = 1'b1;
      settle();
      total++;
      if (rd_valid !== (3'b001 << exp_owner[k]) || rd_data !== beat) begin
        bad++;
        $display("FAIL rr_return%0d: rd_valid=%b rd_data=%h, required rd_valid=%b rd_data=%h",
                 k, rd_valid, rd_data, 3'b001 << exp_owner[k], beat);
      end
      tick();
      avl_readdatavalid = 1'b0;
      $display("test_round_robin: grant %0d owner %0d", k, exp_owner[k]);
    end
  endtask

  task automatic test_lock_burst();
    bit ok;
    do_reset();
    local_init_done = 1'b1;
    avl_wait_request_n = 1'b1;
    req_address = {26'h200, 26'h100, 26'h0};
    req_lock  = 3'b010;
    req_valid = 3'b110;
    wait_cmd(ok);
    total++;
    if (!ok || owner !== 2'd1) begin
      bad++;
      $display("FAIL lock_first_grant: ok=%0b owner=%0d, required owner=1", ok, owner);
    end
    for (int i = 0; i < 4; i++) begin
      req_address[26 +: 26] = 26'h100 + 26'(i);
      if (i == 3) req_lock = 3'b000;
      settle();
      total++;
      if (avl_read !== 1'b1 || owner !== 2'd1 || avl_address !== 26'h100 + 26'(i) || req_ready !== 3'b010) begin
        bad++;
        $display("FAIL lock_read%0d: rd=%0b owner=%0d addr=%h ready=%b, required 1 1 %h 010",
                 i, avl_read, owner, avl_address, req_ready, 26'h100 + 26'(i));
      end
      tick();
    end
    req_valid = 3'b100;
    settle();
    total++;
    if (busy !== 1'b1 || owner !== 2'd1 || avl_read !== 1'b0 || avl_write !== 1'b0) begin
      bad++;
      $display("FAIL lock_drain_entry: busy=%0b owner=%0d rd=%0b wr=%0b, required 1 1 0 0", busy, owner, avl_read, avl_write);
    end
    for (int b = 0; b < 4; b++) begin
      avl_readdatavalid = 1'b1;
      settle();
      total++;
      if (rd_valid !== 3'b010 || avl_read !== 1'b0) begin
        bad++;
        $display("FAIL lock_drain_beat%0d: rd_valid=%b rd=%0b, required 010 0", b, rd_valid, avl_read);
      end
      tick();
    end
    avl_readdatavalid = 1'b0;
    wait_cmd(ok);
    total++;
    if (!ok || owner !== 2'd2 || avl_address !== 26'h200 || protocol_err !== 1'b0) begin
      bad++;
      $display("FAIL lock_next_grant: ok=%0b owner=%0d addr=%h err=%0b, required owner=2 addr=200 err=0",
               ok, owner, avl_address, protocol_err);
    end
    $display("test_lock_burst: done");
  endtask

  task automatic test_backpressure();
    logic [127:0] wd;
    bit ok;
    wd = {4{32'hA5A5A5A5}};
    do_reset();
    local_init_done = 1'b1;
    avl_wait_request_n = 1'b0;
    req_address[25:0] = 26'h3FF;
    req_writedata[127:0] = wd;
    req_write = 3'b001;
    req_valid = 3'b001;
    wait_cmd(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL bp_grant: no write presented within bound, required avl_write=1");
    end
    for (int c = 0; c < 5; c++) begin
      settle();
      total++;
      if (avl_write !== 1'b1 || avl_burstbegin !== 1'b1 || avl_address !== 26'h3FF ||
          avl_writedata !== wd || req_ready !== 3'b000) begin
        bad++;
        $display("FAIL bp_hold%0d: wr=%0b bb=%0b addr=%h wd=%h ready=%b, required 1 1 3ff %h 000",
                 c, avl_write, avl_burstbegin, avl_address, avl_writedata, req_ready, wd);
      end
      tick();
    end
    avl_wait_request_n = 1'b1;
    settle();
    total++;
    if (req_ready !== 3'b001 || avl_write !== 1'b1) begin
      bad++;
      $display("FAIL bp_accept: ready=%b wr=%0b, required 001 1", req_ready, avl_write);
    end
    tick();
    req_valid = 3'b000;
    settle();
    total++;
    if (busy !== 1'b0 || avl_write !== 1'b0 || avl_address !== 26'd0 || avl_writedata !== 128'd0) begin
      bad++;
      $display("FAIL bp_release: busy=%0b wr=%0b addr=%h wd=%h, required all zero", busy, avl_write, avl_address, avl_writedata);
    end
    $display("test_backpressure: done");
  endtask

  task automatic test_saturation();
    bit ok;
    do_reset();
    local_init_done = 1'b1;
    avl_wait_request_n = 1'b1;
    req_address[25:0] = 26'h40;
    req_lock  = 3'b001;
    req_valid = 3'b001;
    wait_cmd(ok);
    for (int i = 0; i < 14; i++) begin
      settle();
      total++;
      if (avl_read !== 1'b1 || req_ready !== 3'b001) begin
        bad++;
        $display("FAIL sat_read%0d: rd=%0b ready=%b, required 1 001", i, avl_read, req_ready);
      end
      tick();
    end
    avl_readdatavalid = 1'b1;
    settle();
    total++;
    if (avl_read !== 1'b1 || req_ready !== 3'b001) begin
      bad++;
      $display("FAIL sat_simultaneous: rd=%0b ready=%b, required 1 001", avl_read, req_ready);
    end
    tick();
    avl_readdatavalid = 1'b0;
    settle();
    total++;
    if (avl_read !== 1'b1) begin
      bad++;
      $display("FAIL sat_after_simul: rd=%0b, required 1 (14 outstanding)", avl_read);
    end
    tick();
    for (int c = 0; c < 2; c++) begin
      settle();
      total++;
      if (avl_read !== 1'b0 || avl_burstbegin !== 1'b0 || req_ready !== 3'b000 || busy !== 1'b1) begin
        bad++;
        $display("FAIL sat_withheld%0d: rd=%0b bb=%0b ready=%b busy=%0b, required 0 0 000 1",
                 c, avl_read, avl_burstbegin, req_ready, busy);
      end
      tick();
    end
    req_lock  = 3'b000;
    req_valid = 3'b000;
    tick();
    for (int b = 0; b < 15; b++) begin
      avl_readdatavalid = 1'b1;
      settle();
      total++;
      if (rd_valid !== 3'b001 || busy !== 1'b1) begin
        bad++;
        $display("FAIL sat_drain_beat%0d: rd_valid=%b busy=%0b, required 001 1", b, rd_valid, busy);
      end
      tick();
    end
    avl_readdatavalid = 1'b0;
    settle();
    total++;
    if (protocol_err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL sat_drain_end: err=%0b busy=%0b, required 0 1", protocol_err, busy);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL sat_idle: busy=%0b, required 0", busy);
    end
    $display("test_saturation: done");
  endtask

  task automatic test_error();
    do_reset();
    avl_readdatavalid = 1'b1;
    settle();
    total++;
    if (rd_valid !== 3'b000 || protocol_err !== 1'b0) begin
      bad++;
      $display("FAIL err_pulse: rd_valid=%b err=%0b, required 000 0", rd_valid, protocol_err);
    end
    tick();
    avl_readdatavalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      settle();
      total++;
      if (protocol_err !== 1'b1 || rd_valid !== 3'b000) begin
        bad++;
        $display("FAIL err_sticky%0d: err=%0b rd_valid=%b, required 1 000", c, protocol_err, rd_valid);
      end
      tick();
    end
    reset = 1'b1;
    settle();
    total++;
    if (protocol_err !== 1'b0) begin
      bad++;
      $display("FAIL err_cleared: err=%0b, required 0", protocol_err);
    end
    reset = 1'b0;
    $display("test_error: done");
  endtask

  task automatic test_reset_midflight();
    bit ok;
    do_reset();
    local_init_done = 1'b1;
    avl_wait_request_n = 1'b1;
    req_lock  = 3'b001;
    req_valid = 3'b001;
    wait_cmd(ok);
    tick();
    tick();
    reset = 1'b1;
    settle();
    total++;
    if (busy !== 1'b0 || avl_read !== 1'b0 || owner !== 2'd0 || protocol_err !== 1'b0) begin
      bad++;
      $display("FAIL midflight_reset: busy=%0b rd=%0b owner=%0d err=%0b, required 0 0 0 0", busy, avl_read, owner, protocol_err);
    end
    clear_inputs();
    reset = 1'b0;
    tick();
    avl_readdatavalid = 1'b1;
    settle();
    total++;
    if (rd_valid !== 3'b000) begin
      bad++;
      $display("FAIL midflight_rdvalid: rd_valid=%b, required 000", rd_valid);
    end
    tick();
    avl_readdatavalid = 1'b0;
    settle();
    total++;
    if (protocol_err !== 1'b1) begin
      bad++;
      $display("FAIL midflight_err: err=%0b, required 1", protocol_err);
    end
    $display("test_reset_midflight: done");
  endtask

  initial begin
    test_reset();
    test_init_gating();
    test_round_robin();
    test_lock_burst();
    test_backpressure();
    test_saturation();
    test_error();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
